// File: rtl/rf_pkg.sv
// Shared register-file definitions: widths, write-back request record and
// the source selector used by the write-back arbiter.
package rf_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  // One pending register-file write: destination and value.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  // Which producer owns the write port in a given cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LD   = 2'd2
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of write-back requests for buffered load results.
// The head entry is read combinationally so the arbiter can drain it in the
// same cycle it decides to; an entry pushed this cycle is not visible at the
// head until the following cycle.
module wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  wb_req_t                      push_req,
  input  logic                         pop,
  output wb_req_t                      head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_req_t        mem [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths keep strict order.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy registers; reset flushes any buffered entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_req;
  end

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Single write-port driver for the integer register file. ALU results win
// the port by default; buffered load results take idle slots, and a head
// that has lost STARVE_MAX times in a row is forced through (stalling the
// ALU). A per-register busy scoreboard tracks outstanding loads.
module reg_writeback_arbiter
  import rf_pkg::*;
#(
  parameter int M          = 31,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                ALU_VALID,
  input  logic [REG_AW-1:0]   ALU_RD,
  input  logic [M:0]          ALU_DATA,
  output logic                STALL,
  input  logic                LD_VALID,
  output logic                LD_READY,
  input  logic [REG_AW-1:0]   LD_RD,
  input  logic [M:0]          LD_DATA,
  input  logic                ISSUE_VALID,
  input  logic [REG_AW-1:0]   ISSUE_RD,
  output logic                EN,
  output logic [REG_AW-1:0]   WA,
  output logic [M:0]          WD,
  output logic [NUM_REGS-1:0] BUSY
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [CW-1:0]       fifo_count;
  logic                fifo_full, fifo_empty;
  wb_req_t             fifo_head, push_req;
  logic                push, pop;
  wb_src_e             src;
  logic                force_drain, alu_write;

  logic [AW-1:0]       age_q, age_d;
  logic                en_q, en_d;
  logic [REG_AW-1:0]   wa_q, wa_d;
  logic [M:0]          wd_q, wd_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Loads to r0 complete their handshake but are dropped here.
  assign LD_READY = (fifo_count < CW'(DEPTH));
  assign push     = LD_VALID && LD_READY && (LD_RD != '0);
  assign push_req = '{rd: LD_RD, data: XLEN'(LD_DATA)};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (CLK),
    .rst_n    (RST_N),
    .push     (push),
    .push_req (push_req),
    .pop      (pop),
    .head     (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Pick the write-port owner: starved load, then ALU, then any load.
  always_comb begin
    force_drain = !fifo_empty && (age_q == AW'(STARVE_MAX));
    alu_write   = ALU_VALID && (ALU_RD != '0);
    src         = SRC_NONE;
    STALL       = 1'b0;
    if (force_drain) begin
      src   = SRC_LD;
      STALL = ALU_VALID;
    end else if (alu_write) begin
      src = SRC_ALU;
    end else if (!fifo_empty) begin
      src = SRC_LD;
    end
    pop = (src == SRC_LD);
  end

  // Next write-port values and head age; address/data hold when idle.
  always_comb begin
    en_d = (src != SRC_NONE);
    wa_d = wa_q;
    wd_d = wd_q;
    case (src)
      SRC_ALU: begin
        wa_d = ALU_RD;
        wd_d = ALU_DATA;
      end
      SRC_LD: begin
        wa_d = fifo_head.rd;
        wd_d = (M + 1)'(fifo_head.data);
      end
      default: ;
    endcase
    if (fifo_empty || pop)
      age_d = '0;
    else if (age_q != AW'(STARVE_MAX))
      age_d = age_q + 1'b1;
    else
      age_d = age_q;
  end

  // Scoreboard bits: a new issue beats a same-cycle drain; r0 never busy.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
    if (gi == 0) begin : g_zero
      assign busy_d[gi] = 1'b0;
    end else begin : g_reg
      logic set_hit, clr_hit;
      assign set_hit    = ISSUE_VALID && (ISSUE_RD == REG_AW'(gi));
      assign clr_hit    = pop && (fifo_head.rd == REG_AW'(gi));
      assign busy_d[gi] = set_hit | (busy_q[gi] & ~clr_hit);
    end
  end

  // Output, age and scoreboard registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      en_q   <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
      age_q  <= '0;
      busy_q <= '0;
    end else begin
      en_q   <= en_d;
      wa_q   <= wa_d;
      wd_q   <= wd_d;
      age_q  <= age_d;
      busy_q <= busy_d;
    end
  end

  assign EN   = en_q;
  assign WA   = wa_q;
  assign WD   = wd_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed, table-driven bench for reg_writeback_arbiter (DEPTH=2,
// STARVE_MAX=4). Each row drives one cycle of inputs, checks the
// combinational STALL/LD_READY before the edge and EN/WA/WD/BUSY after it.
module tb_reg_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, ld_valid, issue_valid;
  logic [4:0]  alu_rd, ld_rd, issue_rd;
  logic [31:0] alu_data, ld_data;
  logic        stall, ld_ready, en;
  logic [4:0]  wa;
  logic [31:0] wd, busy;

  int checks = 0;
  int errors = 0;
  int cur_row = -1;

  always #5 clk = ~clk;

  reg_writeback_arbiter #(.M(31), .DEPTH(2), .STARVE_MAX(4)) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .ALU_VALID   (alu_valid),
    .ALU_RD      (alu_rd),
    .ALU_DATA    (alu_data),
    .STALL       (stall),
    .LD_VALID    (ld_valid),
    .LD_READY    (ld_ready),
    .LD_RD       (ld_rd),
    .LD_DATA     (ld_data),
    .ISSUE_VALID (issue_valid),
    .ISSUE_RD    (issue_rd),
    .EN          (en),
    .WA          (wa),
    .WD          (wd),
    .BUSY        (busy)
  );

  typedef struct {
    logic        av;  logic [4:0] ar;  logic [31:0] ad;
    logic        lv;  logic [4:0] lr;  logic [31:0] ld;
    logic        iv;  logic [4:0] ir;
    logic        e_stall, e_ldr, e_en;
    logic [4:0]  e_wa;
    logic [31:0] e_wd, e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                   input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                   input logic iv, input logic [4:0] ir,
                   input logic st, input logic rdy, input logic e,
                   input logic [4:0] a, input logic [31:0] d, input logic [31:0] b);
    vec_t x;
    x.av = av; x.ar = ar; x.ad = ad;
    x.lv = lv; x.lr = lr; x.ld = ld;
    x.iv = iv; x.ir = ir;
    x.e_stall = st; x.e_ldr = rdy; x.e_en = e;
    x.e_wa = a; x.e_wd = d; x.e_busy = b;
    vecs.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (row %0d): got 0x%08h, expected 0x%08h", nm, cur_row, act, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    issue_valid = 0; issue_rd = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ALU path
    v(1,5,32'hDEADBEEF, 0,0,0, 0,0,  0,1,1,5,32'hDEADBEEF,32'h0);
    v(0,0,0,            0,0,0, 0,0,  0,1,0,5,32'hDEADBEEF,32'h0);
    // Load buffering: issue, push, drain two cycles later
    v(0,0,0,            0,0,0, 1,7,  0,1,0,5,32'hDEADBEEF,32'h80);
    v(0,0,0, 1,7,32'h1234,     0,0,  0,1,0,5,32'hDEADBEEF,32'h80);
    v(0,0,0,            0,0,0, 0,0,  0,1,1,7,32'h1234,32'h0);
    v(0,0,0,            0,0,0, 0,0,  0,1,0,7,32'h1234,32'h0);
    // Full FIFO under continuous ALU traffic, forced drain, held ALU retry
    v(1,1,32'h101, 1,10,32'hA0, 0,0, 0,1,1,1,32'h101,32'h0);
    v(1,2,32'h102, 1,11,32'hA1, 0,0, 0,1,1,2,32'h102,32'h0);
    v(1,3,32'h103, 1,12,32'hA2, 0,0, 0,0,1,3,32'h103,32'h0);
    v(1,4,32'h104, 1,12,32'hA2, 0,0, 0,0,1,4,32'h104,32'h0);
    v(1,5,32'h105, 1,12,32'hA2, 0,0, 0,0,1,5,32'h105,32'h0);
    v(1,6,32'h106, 1,12,32'hA2, 0,0, 1,0,1,10,32'hA0,32'h0);
    v(1,6,32'h106, 1,12,32'hA2, 0,0, 0,1,1,6,32'h106,32'h0);
    v(0,0,0,            0,0,0, 0,0,  0,0,1,11,32'hA1,32'h0);
    v(0,0,0,            0,0,0, 0,0,  0,1,1,12,32'hA2,32'h0);
    v(0,0,0,            0,0,0, 0,0,  0,1,0,12,32'hA2,32'h0);
    // Starvation: one buffered load vs continuous ALU
    v(0,0,0, 1,20,32'hBEEF0020, 0,0, 0,1,0,12,32'hA2,32'h0);
    v(1,1,32'h201, 0,0,0, 0,0,       0,1,1,1,32'h201,32'h0);
    v(1,2,32'h202, 0,0,0, 0,0,       0,1,1,2,32'h202,32'h0);
    v(1,3,32'h203, 0,0,0, 0,0,       0,1,1,3,32'h203,32'h0);
    v(1,4,32'h204, 0,0,0, 0,0,       0,1,1,4,32'h204,32'h0);
    v(1,5,32'h205, 0,0,0, 0,0,       1,1,1,20,32'hBEEF0020,32'h0);
    v(1,5,32'h205, 0,0,0, 0,0,       0,1,1,5,32'h205,32'h0);
    v(1,6,32'h206, 0,0,0, 0,0,       0,1,1,6,32'h206,32'h0);
    v(0,0,0,            0,0,0, 0,0,  0,1,0,6,32'h206,32'h0);
    // ALU_RD=0 with pending load: load takes the slot, no stall
    v(0,0,0, 1,21,32'h21,      0,0,  0,1,0,6,32'h206,32'h0);
    v(1,0,32'h999, 0,0,0, 0,0,       0,1,1,21,32'h21,32'h0);
    // LD_RD=0 handshake: accepted, never written
    v(0,0,0, 1,0,32'h77,       0,0,  0,1,0,21,32'h21,32'h0);
    v(0,0,0,            0,0,0, 0,0,  0,1,0,21,32'h21,32'h0);
    // Issue to r3 in the same cycle r3 drains: BUSY[3] stays set
    v(0,0,0,            0,0,0, 1,3,  0,1,0,21,32'h21,32'h8);
    v(0,0,0, 1,3,32'h33,       0,0,  0,1,0,21,32'h21,32'h8);
    v(0,0,0,            0,0,0, 1,3,  0,1,1,3,32'h33,32'h8);
    v(0,0,0,            0,0,0, 0,0,  0,1,0,3,32'h33,32'h8);
    v(0,0,0, 1,3,32'h34,       0,0,  0,1,0,3,32'h33,32'h8);
    v(0,0,0,            0,0,0, 0,0,  0,1,1,3,32'h34,32'h0);
    v(0,0,0,            0,0,0, 0,0,  0,1,0,3,32'h34,32'h0);
    // Two loads buffered behind ALU traffic, BUSY = r4|r7
    v(1,1,32'h301, 1,4,32'h44, 1,4,  0,1,1,1,32'h301,32'h10);
    v(1,2,32'h302, 1,7,32'h77, 1,7,  0,1,1,2,32'h302,32'h90);

    // Power-on reset
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_en",   {31'b0, en},       32'h0);
    chk("reset_wa",   {27'b0, wa},       32'h0);
    chk("reset_wd",   wd,                32'h0);
    chk("reset_busy", busy,              32'h0);
    chk("reset_ldr",  {31'b0, ld_ready}, 32'h1);
    chk("reset_stall",{31'b0, stall},    32'h0);
    $display("reset: en=%b wa=%0d wd=%h busy=%h ld_ready=%b", en, wa, wd, busy, ld_ready);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      cur_row = i;
      alu_valid = vecs[i].av; alu_rd = vecs[i].ar; alu_data = vecs[i].ad;
      ld_valid = vecs[i].lv; ld_rd = vecs[i].lr; ld_data = vecs[i].ld;
      issue_valid = vecs[i].iv; issue_rd = vecs[i].ir;
      #1;
      chk("stall",    {31'b0, stall},    {31'b0, vecs[i].e_stall});
      chk("ld_ready", {31'b0, ld_ready}, {31'b0, vecs[i].e_ldr});
      @(posedge clk);
      #1;
      chk("en",   {31'b0, en}, {31'b0, vecs[i].e_en});
      chk("wa",   {27'b0, wa}, {27'b0, vecs[i].e_wa});
      chk("wd",   wd,          vecs[i].e_wd);
      chk("busy", busy,        vecs[i].e_busy);
      $display("row %0d: alu=%b/%0d ld=%b/%0d iss=%b/%0d -> stall=%b ld_ready=%b en=%b wa=%0d wd=%h busy=%h",
               i, vecs[i].av, vecs[i].ar, vecs[i].lv, vecs[i].lr, vecs[i].iv, vecs[i].ir,
               stall, ld_ready, en, wa, wd, busy);
    end

    // Reset asserted mid-operation with two loads buffered
    cur_row = -2;
    idle_inputs();
    #1;
    chk("pre_rst_busy", busy,              32'h90);
    chk("pre_rst_ldr",  {31'b0, ld_ready}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en",   {31'b0, en},       32'h0);
    chk("mid_rst_busy", busy,              32'h0);
    chk("mid_rst_ldr",  {31'b0, ld_ready}, 32'h1);
    chk("mid_rst_wa",   {27'b0, wa},       32'h0);
    $display("mid-op reset: en=%b busy=%h ld_ready=%b", en, busy, ld_ready);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("post_rst_en",   {31'b0, en}, 32'h0);
      chk("post_rst_wd",   wd,          32'h0);
      chk("post_rst_busy", busy,        32'h0);
      $display("post-reset cycle %0d: en=%b wa=%0d wd=%h busy=%h", k, en, wa, wd, busy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_writeback_arbiter.md
# reg_writeback_arbiter

Single write-port driver for the integer register file. It merges single-cycle ALU results and variable-latency load results into one registered write per cycle (EN/WA/WD). Load results are buffered in a small FIFO. A per-register busy scoreboard lets decode stall on registers that still have an outstanding load. It sits between the execute/LSU stages and the register file write port.

## Interface
- M, 31, data MSB; data width is M+1
- DEPTH, 2, load FIFO entries (≥1)
- STARVE_MAX, 4, consecutive cycles a FIFO head may lose to the ALU before it is forced through
- CLK  in  1  clock; all state updates on posedge
- RST_N  in  1  reset; asynchronous and active-low
- ALU_VALID  in  1  ALU result present this cycle
- ALU_RD  in  5  ALU destination register
- ALU_DATA  in  M+1  ALU result
- STALL  out  1  ALU result not accepted this cycle; producer holds ALU_VALID/ALU_RD/ALU_DATA
- LD_VALID  in  1  load result offered
- LD_READY  out  1  load result accepted when LD_VALID && LD_READY
- LD_RD  in  5  load destination register
- LD_DATA  in  M+1  load data
- ISSUE_VALID  in  1  decode issues a load this cycle
- ISSUE_RD  in  5  destination of the issued load
- EN  out  1  register file write enable (registered)
- WA  out  5  register file write address (registered)
- WD  out  M+1  register file write data (registered)
- BUSY  out  32  BUSY[r]=1 while a load to r is outstanding

## Operation
- LD_READY = (count < DEPTH); combinational from the FIFO occupancy only.
- A load accepted with LD_RD=0 completes its handshake but is not stored.
- Each cycle exactly one source is selected. The selected source is registered onto EN/WA/WD at the next edge. Priority order:
  - force: FIFO non-empty && age == STARVE_MAX → drain FIFO head; STALL=1.
  - ALU_VALID && ALU_RD != 0 → write ALU; STALL=0.
  - FIFO non-empty → drain FIFO head.
  - otherwise EN ← 0; WA and WD hold their values.
- ALU_VALID with ALU_RD=0 is accepted (STALL=0) and writes nothing. The slot goes to the FIFO if the FIFO is non-empty.
- STALL is combinational and is only ever asserted together with ALU_VALID.
- age counter:
  - cleared when the FIFO is empty or the head is drained;
  - otherwise increments, saturating at STARVE_MAX.
- Scoreboard:
  - ISSUE_VALID && ISSUE_RD != 0 sets BUSY[ISSUE_RD] at the next edge.
  - Draining a load to rd clears BUSY[rd] at the same edge that drives EN.
  - If set and clear hit the same register in the same cycle, set wins.
- BUSY[0] is constant 0.

## Timing
- Reset values: EN=0, WA=0, WD=0, BUSY=0, FIFO empty, age=0, so LD_READY=1 and STALL=0.
- ALU latency: valid at cycle n → EN/WA/WD at cycle n+1.
- Load latency is at least 2 cycles: push at edge n, head eligible in cycle n+1, visible on EN at n+2.
- A push and a drain in the same cycle are both allowed; occupancy is unchanged.
- A newly pushed entry is never drained in the cycle it is pushed.
- Full FIFO: LD_READY=0. A drain in that cycle does not raise LD_READY until the next cycle.
- Wrap-around: read and write pointers wrap modulo DEPTH; FIFO order is strictly preserved.
- Reset asserted mid-operation:
  - immediately clears all state and flushes the FIFO; buffered loads are lost;
  - upstream stages are reset by the same RST_N.

## Structure
- Shared package rf_pkg:
  - XLEN=32, REG_AW=5, NUM_REGS=32;
  - typedef wb_req_t {rd, data};
  - typedef wb_src_e {SRC_NONE, SRC_ALU, SRC_LD}.
- Sub-module wb_fifo:
  - synchronous FIFO of wb_req_t with DEPTH entries;
  - ports: push, pop, head, count, full, empty; same reset.
- The top holds arbitration, the age counter, the output registers and the scoreboard.

## Test plan
- ALU path: reset; ALU_VALID=1, ALU_RD=5, ALU_DATA=0xDEADBEEF for one cycle → next cycle EN=1, WA=5, WD=0xDEADBEEF; following cycle EN=0.
- Load buffering: ISSUE rd=7; LD_VALID with rd=7, data=0x1234 pushed at cycle 2; no ALU traffic → EN=1, WA=7, WD=0x1234 at cycle 4; BUSY[7] goes 1→0 at the same edge.
- Full FIFO: DEPTH=2, three loads offered back-to-back while the ALU writes every cycle → LD_READY=0 on the 3rd offer; 3rd load accepted only after the first drain.
- Starvation: load in FIFO, ALU_VALID continuous with rd=1..9 → after 4 lost cycles STALL=1 for one cycle, the load is written, and the held ALU result is written the next cycle.
- Corner cases:
  - ALU_RD=0 with a pending load → the load is written, STALL=0;
  - LD_RD=0 handshake → no write;
  - ISSUE rd=3 in the same cycle as a drain of rd=3 → BUSY[3] stays 1.
- Reset mid-op: two entries buffered, BUSY=0x0000_0090, RST_N low for one cycle → EN=0, BUSY=0, LD_READY=1, no stale write after release.
